pmp_csr_regs: RTL
=================

# pmp_csr_regs

Configuration-side counterpart of the per-entry PMP address matchers. It holds the architectural pmpcfg/pmpaddr CSR state for RV64 and serves CSR read/write requests from the CSR file through a valid/ready request and response handshake. It applies WARL legalization and lock rules. It drives the per-entry address, address mode and permissions that the matcher array consumes.

## Interface
Parameters:
- NR_ENTRIES, 16: number of implemented PMP entries, 0..16.
- PMP_LEN, 54: width of each stored pmpaddr register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  CSR request valid.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  12  CSR address.
- req_wdata_i  in  64  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  64  read data; for writes, the post-write legalized value.
- rsp_err_o  out  1  illegal CSR address.
- update_o  out  1  one-cycle pulse: stored PMP state changed.
- conf_addr_o  out  NR_ENTRIES x PMP_LEN  pmpaddr per entry.
- conf_mode_o  out  NR_ENTRIES x riscv::pmp_addr_mode_t  A field per entry.
- conf_access_o  out  NR_ENTRIES x 3  {X,W,R} per entry.
- conf_locked_o  out  NR_ENTRIES  L bit per entry.

## Operation
- Cfg byte i layout: bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bits6:5 hardwired 0, bit7 L.
- Address map:
  - 0x3A0 (pmpcfg0) holds bytes 0..7.
  - 0x3A2 (pmpcfg2) holds bytes 8..15.
  - 0x3A1 and 0x3A3 are illegal on RV64 and set rsp_err_o.
  - 0x3B0+i is pmpaddr i, for i = 0..15.
  - Any other address: rsp_err_o = 1, rdata 0, no state change.
- Unimplemented entries (i >= NR_ENTRIES): read 0, writes dropped, no error.
- Cfg write, per byte, independently:
  - Skip the byte if the stored L = 1.
  - Skip the byte if the new value has W = 1 and R = 0 (reserved); the old byte is kept.
  - Otherwise store the byte with bits6:5 cleared.
- pmpaddr i write:
  - Skip if L[i] = 1.
  - Skip if i+1 < NR_ENTRIES and L[i+1] = 1 and mode[i+1] = TOR.
  - Otherwise store wdata[PMP_LEN-1:0].
  - Reads are zero-extended to 64 bits.
- L is sticky: only reset clears it.
- FSM:
  - IDLE: req_ready_o = 1. On req_valid_i, the request is accepted: perform the write (if any), capture rdata/err, go to RESP.
  - RESP: req_ready_o = 0, rsp_valid_o = 1. When rsp_ready_i = 1, return to IDLE.
- update_o: 1 in the first RESP cycle after an accepted write whose legalized result differs from the previous stored state; 0 otherwise.

## Timing
- Reset values:
  - All cfg bytes 0 (OFF, unlocked, no permissions); all pmpaddr 0.
  - FSM IDLE: req_ready_o = 1, rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, update_o = 0.
- Latency:
  - Response appears the cycle after acceptance; a back-to-back minimum of 2 cycles per request.
  - Register and conf_* updates are visible the cycle after the accepting edge, i.e. together with rsp_valid_o.
- Response fields stay stable while rsp_valid_o = 1 and rsp_ready_i = 0.
- The next request can only be accepted in the cycle after the response handshake.
- A single write touching several cfg bytes of mixed lock state updates only the unlocked, legal bytes in the same cycle.
- A write setting L and changing A/RWX in the same byte takes effect; later writes to that byte are ignored.
- Reset asserted mid-transaction (RESP) drops the response immediately: FSM goes to IDLE and all state goes to reset values asynchronously.

## Test plan
- Reset, then read 0x3A0 -> rsp_rdata_o = 0, rsp_err_o = 0, one cycle latency; all conf_mode_o = OFF.
- Write 0x3B0 = 0x2000_0FFF, then 0x3A0 = 0x0000_0000_0000_001F -> entry 0 mode NAPOT, access 3'b111, conf_addr_o[0] = 0x2000_0FFF; update_o pulses once per write.
- Write 0x3A0 = 0x0000_0000_0000_0A02 -> byte0 (W without R) kept at old value, byte1 = 0x0A (TOR, W=1, R=0? no: 0x0A = R=0, W=1, so also rejected). Then write 0x0000_0000_0000_0B03 -> byte0 = 0x03, byte1 = 0x0B.
- Set byte1 = 0x89 (L, TOR, R) and write pmpaddr0 = 0x1234 -> pmpaddr0 unchanged, update_o = 0. Write 0x3A0 byte1 = 0x00 -> byte1 stays 0x89.
- Access 0x3A1 and 0x3C0 -> rsp_err_o = 1, rdata 0, no state change. With NR_ENTRIES = 8, write 0x3B9 -> ignored, read 0, no error.
- Hold rsp_ready_i = 0 for 5 cycles while req_valid_i stays high -> rsp fields stable, req_ready_o = 0. Then assert rst_ni low in RESP -> rsp_valid_o = 0 and req_ready_o = 1 immediately.

Source files
------------

// File: rtl/pmp_csr_regs.sv
// PMP configuration CSR block: holds pmpcfg/pmpaddr state for RV64, serves CSR
// requests over a valid/ready handshake and drives the per-entry matcher configuration.

package riscv;
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;
endpackage

module pmp_csr_regs #(
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned PMP_LEN    = 54
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic                                  req_we_i,
  input  logic [11:0]                           req_addr_i,
  input  logic [63:0]                           req_wdata_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [63:0]                           rsp_rdata_o,
  output logic                                  rsp_err_o,
  output logic                                  update_o,
  output logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_o,
  output riscv::pmp_addr_mode_t [NR_ENTRIES-1:0] conf_mode_o,
  output logic [NR_ENTRIES-1:0][2:0]            conf_access_o,
  output logic [NR_ENTRIES-1:0]                 conf_locked_o
);

  localparam logic [15:0] IMPL_MASK = 16'((17'd1 << NR_ENTRIES) - 17'd1);
  localparam logic [7:0]  CFG_WMASK = 8'h9F;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  accept;

  logic [7:0]            cfg_q  [16];
  logic [7:0]            cfg_d  [16];
  logic [PMP_LEN-1:0]    addr_q [16];
  logic [PMP_LEN-1:0]    addr_d [16];

  logic [63:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  update_q, update_d;

  logic                  is_cfg, is_addr, changed;
  logic [15:0]           next_tor_lock;
  logic                  unused_wdata;

  assign unused_wdata = ^req_wdata_i;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid_i) state_d = S_RESP;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
  end

  assign accept = req_valid_i & req_ready_o;

  // An address register is also frozen when the entry above it is a locked TOR top.
  always_comb begin
    next_tor_lock = '0;
    for (int e = 0; e < 15; e++) begin
      next_tor_lock[e] = IMPL_MASK[e+1] & cfg_q[e+1][7] & (cfg_q[e+1][4:3] == 2'b01);
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode, WARL legalization and read-data mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    rdata_d = '0;
    changed = 1'b0;
    is_cfg  = (req_addr_i == 12'h3A0) || (req_addr_i == 12'h3A2);
    is_addr = (req_addr_i[11:4] == 8'h3B);
    err_d   = !(is_cfg || is_addr);

    for (int e = 0; e < 16; e++) begin
      if (accept && req_we_i && IMPL_MASK[e]) begin
        if (is_cfg && (req_addr_i[1] == (e >= 8)) && !cfg_q[e][7] &&
            !(req_wdata_i[(e%8)*8+1] && !req_wdata_i[(e%8)*8])) begin
          cfg_d[e] = req_wdata_i[(e%8)*8 +: 8] & CFG_WMASK;
        end
        if (is_addr && (req_addr_i[3:0] == 4'(e)) && !cfg_q[e][7] && !next_tor_lock[e]) begin
          addr_d[e] = req_wdata_i[PMP_LEN-1:0];
        end
      end
    end

    // Read data reflects the post-write state, so writes return the legalized value.
    for (int e = 0; e < 16; e++) begin
      if (IMPL_MASK[e]) begin
        if (is_cfg && (req_addr_i[1] == (e >= 8))) rdata_d[(e%8)*8 +: 8] = cfg_d[e];
        if (is_addr && (req_addr_i[3:0] == 4'(e))) rdata_d = 64'(addr_d[e]);
        if ((cfg_d[e] != cfg_q[e]) || (addr_d[e] != addr_q[e])) changed = 1'b1;
      end
    end

    update_d = accept & req_we_i & changed;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the CSR arrays are architectural state with defined reset values, so they are reset explicitly.
      for (int e = 0; e < 16; e++) begin
        cfg_q[e]  <= '0;
        addr_q[e] <= '0;
      end
      rdata_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      update_q <= update_d;
      if (accept) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign update_o    = update_q;

  always_comb begin
    for (int e = 0; e < NR_ENTRIES; e++) begin
      conf_addr_o[e]   = addr_q[e];
      conf_mode_o[e]   = riscv::pmp_addr_mode_t'(cfg_q[e][4:3]);
      conf_access_o[e] = cfg_q[e][2:0];
      conf_locked_o[e] = cfg_q[e][7];
    end
  end

endmodule
